// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader and the downstream core:
// FSM state encodings, default instruction RAM depth and instruction byte order.
package prog_loader_pkg;

  localparam int RAM_WORDS_DEF = 128;

  // Instructions arrive high byte first; these give each byte's bit position in the word.
  localparam int HI_LSB = 8;
  localparam int LO_LSB = 0;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LEN  = 3'd1;
  localparam logic [2:0] S_HI   = 3'd2;
  localparam logic [2:0] S_LO   = 3'd3;
  localparam logic [2:0] S_CSUM = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;
  localparam logic [2:0] S_ERR  = 3'd6;

  function automatic logic is_busy(input logic [2:0] s);
    return (s == S_LEN) || (s == S_HI) || (s == S_LO) || (s == S_CSUM);
  endfunction

  function automatic logic is_parked(input logic [2:0] s);
    return (s == S_IDLE) || (s == S_DONE) || (s == S_ERR);
  endfunction

endpackage

// File: rtl/prog_loader_csum.sv
// Byte-wise XOR accumulator used to verify a load session; clr wins over en.
module loader_csum (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic [7:0] din_i,
  output logic [7:0] acc_o
);

  logic [7:0] acc_q, acc_d;

  always_comb begin
    acc_d = acc_q;
    if (clr_i)     acc_d = 8'h00;
    else if (en_i) acc_d = acc_q ^ din_i;
  end

  always_ff @(posedge clk) begin
    if (rst) acc_q <= 8'h00;
    else     acc_q <= acc_d;
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/prog_loader.sv
// Byte-stream program loader: LEN byte, then N big-endian 16-bit words written to RAM.
// Optional trailing XOR checksum byte when LOADER_CHECKSUM_EN is defined.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter  int RAM_WORDS = RAM_WORDS_DEF,
  localparam int ADDR_W    = $clog2(RAM_WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              core_run,
  output logic              busy,
  output logic              err
);

  // The LEN byte caps a session at 255 words, so an 8-bit counter suffices
  // for any RAM_WORDS up to 256 and still holds the terminal value N.
  localparam logic [8:0] LEN_MAX = 9'(RAM_WORDS);

  logic [2:0]        state_q, state_d;
  logic [7:0]        len_q, len_d;
  logic [7:0]        hi_q, hi_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic [15:0]       word;
  logic              fire;
  logic              start_ok;
  logic              last_word;

  assign fire      = in_valid && in_ready;
  assign start_ok  = start && is_parked(state_q);
  assign last_word = (cnt_q + 8'd1) == len_q;

  always_comb begin
    word = 16'h0000;
    word[HI_LSB +: 8] = hi_q;
    word[LO_LSB +: 8] = in_data;
  end

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] csum_acc;
  logic       csum_en;

  // Every accepted byte except the checksum itself feeds the accumulator.
  assign csum_en = fire && (state_q != S_CSUM);

  loader_csum u_csum (
    .clk   (clk),
    .rst   (rst),
    .clr_i (start_ok),
    .en_i  (csum_en),
    .din_i (in_data),
    .acc_o (csum_acc)
  );
`endif

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    hi_d     = hi_q;
    cnt_d    = cnt_q;
    mem_we_d = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start_ok) begin
          state_d = S_LEN;
          cnt_d   = 8'h00;
        end
      end
      S_LEN: begin
        if (fire) begin
          len_d = in_data;
          if (in_data == 8'h00 || {1'b0, in_data} > LEN_MAX) state_d = S_ERR;
          else                                              state_d = S_HI;
        end
      end
      S_HI: begin
        if (fire) begin
          hi_d    = in_data;
          state_d = S_LO;
        end
      end
      S_LO: begin
        if (fire) begin
          mem_we_d = 1'b1;
          addr_d   = cnt_q[ADDR_W-1:0];
          wdata_d  = word;
          cnt_d    = cnt_q + 8'd1;
          if (last_word) begin
`ifdef LOADER_CHECKSUM_EN
            state_d = S_CSUM;
`else
            state_d = S_DONE;
`endif
          end else begin
            state_d = S_HI;
          end
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (fire) state_d = (in_data == csum_acc) ? S_DONE : S_ERR;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      len_q    <= 8'h00;
      hi_q     <= 8'h00;
      cnt_q    <= 8'h00;
      mem_we_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= 16'h0000;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      hi_q     <= hi_d;
      cnt_q    <= cnt_d;
      mem_we_q <= mem_we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

  assign in_ready  = is_busy(state_q);
  assign busy      = is_busy(state_q);
  assign core_run  = (state_q == S_DONE);
  assign err       = (state_q == S_ERR);
  assign mem_we    = mem_we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader; follows LOADER_CHECKSUM_EN when it is defined.
module tb_prog_loader;

  localparam int RW = 128;
  localparam int AW = 7;

  logic          clk = 1'b0;
  logic          rst, start, in_valid;
  logic [7:0]    in_data;
  logic          in_ready, mem_we, core_run, busy, err;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_wdata;

  int total = 0;
  int bad   = 0;

  logic [AW-1:0] wr_addr[$];
  logic [15:0]   wr_data[$];

  prog_loader #(.RAM_WORDS(RW)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .core_run(core_run), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // RAM write log taken at the falling edge, away from the register updates
  always @(negedge clk) begin
    if (mem_we) begin
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_wdata);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog no_finish");
    $fatal(1);
  end

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int g;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    g = 0;
    while (!in_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (!in_ready) begin
      total++; bad++;
      $display("FAIL handshake_timeout byte=%h in_ready=%b required=1", b, in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; start = 1'b0; in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    clear_log();
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) @(negedge clk);
    total++;
    if ({in_ready, mem_we, core_run, busy, err} !== 5'b0) begin
      bad++;
      $display("FAIL reset_flags got=%b required=00000", {in_ready, mem_we, core_run, busy, err});
    end
    total++;
    if (mem_addr !== 7'd0 || mem_wdata !== 16'h0000) begin
      bad++;
      $display("FAIL reset_mem_bus got=%h/%h required=0/0000", mem_addr, mem_wdata);
    end
    rst = 1'b0;
    // in_valid in IDLE must not move anything
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'h99;
    repeat (3) @(negedge clk);
    total++;
    if ({in_ready, busy, mem_we} !== 3'b000 || wr_addr.size() != 0) begin
      bad++;
      $display("FAIL idle_ignore got=%b writes=%0d required=000 writes=0",
               {in_ready, busy, mem_we}, wr_addr.size());
    end
    in_valid = 1'b0;
    @(negedge clk);
    clear_log();
  endtask

  task automatic test_basic_load();
    clear_log();
    pulse_start();
    total++;
    if ({busy, in_ready, core_run, err} !== 4'b1100) begin
      bad++;
      $display("FAIL start_to_len got=%b required=1100", {busy, in_ready, core_run, err});
    end
    send_byte(8'h02, 0);
    send_byte(8'h12, 0);
    send_byte(8'h05, 0);
    total++;
    if (mem_we !== 1'b1 || mem_addr !== 7'd0 || mem_wdata !== 16'h1205) begin
      bad++;
      $display("FAIL word0_write got=%b/%h/%h required=1/00/1205", mem_we, mem_addr, mem_wdata);
    end
    send_byte(8'h20, 0);
    total++;
    if (mem_we !== 1'b0 || mem_addr !== 7'd0 || mem_wdata !== 16'h1205) begin
      bad++;
      $display("FAIL hold_after_hi got=%b/%h/%h required=0/00/1205", mem_we, mem_addr, mem_wdata);
    end
    send_byte(8'h10, 0);
    total++;
    if (mem_we !== 1'b1 || mem_addr !== 7'd1 || mem_wdata !== 16'h2010) begin
      bad++;
      $display("FAIL word1_write got=%b/%h/%h required=1/01/2010", mem_we, mem_addr, mem_wdata);
    end
`ifdef LOADER_CHECKSUM_EN
    total++;
    if ({core_run, busy} !== 2'b01) begin
      bad++;
      $display("FAIL csum_wait got=%b required=01", {core_run, busy});
    end
    send_byte(8'h25, 0);
`endif
    total++;
    if ({core_run, busy, err} !== 3'b100) begin
      bad++;
      $display("FAIL run_latency got=%b required=100", {core_run, busy, err});
    end
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'hFF;
    repeat (3) @(negedge clk);
    total++;
    if (mem_we !== 1'b0 || mem_addr !== 7'd1 || mem_wdata !== 16'h2010 || core_run !== 1'b1
        || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL done_hold got=%b/%h/%h run=%b rdy=%b required=0/01/2010 run=1 rdy=0",
               mem_we, mem_addr, mem_wdata, core_run, in_ready);
    end
    in_valid = 1'b0;
    total++;
    if (wr_addr.size() != 2) begin
      bad++;
      $display("FAIL basic_write_count got=%0d required=2", wr_addr.size());
    end
  endtask

  task automatic test_gaps_and_start();
    logic [7:0] bytes [6];
    int nb;
    bytes[0] = 8'h02; bytes[1] = 8'h12; bytes[2] = 8'h05;
    bytes[3] = 8'h20; bytes[4] = 8'h10; bytes[5] = 8'h25;
`ifdef LOADER_CHECKSUM_EN
    nb = 6;
`else
    nb = 5;
`endif
    clear_log();
    pulse_start();
    total++;
    if (core_run !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL restart_from_done got=run%b busy%b required=run0 busy1", core_run, busy);
    end
    for (int i = 0; i < nb; i++) begin
      send_byte(bytes[i], int'($urandom_range(0, 3)));
      if (i == 1) begin
        pulse_start();
        total++;
        if (busy !== 1'b1 || in_ready !== 1'b1) begin
          bad++;
          $display("FAIL start_while_busy got=busy%b rdy%b required=busy1 rdy1", busy, in_ready);
        end
      end
    end
    repeat (2) @(negedge clk);
    total++;
    if (wr_addr.size() != 2) begin
      bad++;
      $display("FAIL gap_write_count got=%0d required=2", wr_addr.size());
    end else begin
      total++;
      if (wr_addr[0] !== 7'd0 || wr_data[0] !== 16'h1205 || wr_addr[1] !== 7'd1
          || wr_data[1] !== 16'h2010) begin
        bad++;
        $display("FAIL gap_ram_contents got=%h:%h %h:%h required=00:1205 01:2010",
                 wr_addr[0], wr_data[0], wr_addr[1], wr_data[1]);
      end
    end
    total++;
    if (core_run !== 1'b1) begin
      bad++;
      $display("FAIL gap_done got=%b required=1", core_run);
    end
  endtask

  task automatic test_len_err();
    do_reset();
    pulse_start();
    send_byte(8'h00, 0);
    total++;
    if ({err, in_ready, busy, core_run} !== 4'b1000) begin
      bad++;
      $display("FAIL len_zero got=%b required=1000", {err, in_ready, busy, core_run});
    end
    pulse_start();
    total++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL restart_from_err got=err%b busy%b required=err0 busy1", err, busy);
    end
    send_byte(8'h81, 0);
    total++;
    if ({err, in_ready, busy, core_run} !== 4'b1000) begin
      bad++;
      $display("FAIL len_too_big got=%b required=1000", {err, in_ready, busy, core_run});
    end
    repeat (3) @(negedge clk);
    total++;
    if (wr_addr.size() != 0 || err !== 1'b1) begin
      bad++;
      $display("FAIL err_no_write got=writes%0d err%b required=writes0 err1", wr_addr.size(), err);
    end
    // 0x80 equals RAM_WORDS and is the largest legal length
    pulse_start();
    send_byte(8'h80, 0);
    total++;
    if ({err, busy} !== 2'b01) begin
      bad++;
      $display("FAIL len_max_ok got=%b required=01", {err, busy});
    end
    do_reset();
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum();
    clear_log();
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h70, 0);
    send_byte(8'h03, 0);
    send_byte(8'h72, 0);
    total++;
    if ({core_run, err} !== 2'b10) begin
      bad++;
      $display("FAIL csum_match got=%b required=10", {core_run, err});
    end
    total++;
    if (wr_data.size() != 1 || wr_data[0] !== 16'h7003) begin
      bad++;
      $display("FAIL csum_word got=%0d words required=1 word 7003", wr_data.size());
    end
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h70, 0);
    send_byte(8'h03, 0);
    send_byte(8'h73, 0);
    total++;
    if ({core_run, err} !== 2'b01) begin
      bad++;
      $display("FAIL csum_mismatch got=%b required=01", {core_run, err});
    end
    do_reset();
  endtask
`endif

  task automatic test_reset_mid();
    clear_log();
    pulse_start();
    send_byte(8'h03, 0);
    send_byte(8'hA1, 0);
    send_byte(8'hB2, 0);
    send_byte(8'hC3, 0);
    @(negedge clk);
    rst = 1'b1; start = 1'b1; in_valid = 1'b1; in_data = 8'hD4;
    @(posedge clk);
    #1;
    start = 1'b0; in_valid = 1'b0;
    total++;
    if ({in_ready, mem_we, core_run, busy, err} !== 5'b0 || mem_addr !== 7'd0
        || mem_wdata !== 16'h0000) begin
      bad++;
      $display("FAIL rst_mid_outputs got=%b/%h/%h required=00000/00/0000",
               {in_ready, mem_we, core_run, busy, err}, mem_addr, mem_wdata);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({in_ready, busy, core_run, err} !== 4'b0) begin
      bad++;
      $display("FAIL rst_mid_idle got=%b required=0000", {in_ready, busy, core_run, err});
    end
    total++;
    if (wr_addr.size() != 1) begin
      bad++;
      $display("FAIL rst_mid_count got=%0d required=1", wr_addr.size());
    end else begin
      total++;
      if (wr_addr[0] !== 7'd0 || wr_data[0] !== 16'hA1B2) begin
        bad++;
        $display("FAIL rst_mid_word got=%h:%h required=00:A1B2", wr_addr[0], wr_data[0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_gaps_and_start();
    test_len_err();
`ifdef LOADER_CHECKSUM_EN
    test_checksum();
`endif
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter RAM_WORDS, default 128, instruction RAM depth in 16-bit words; ADDR_W = clog2(RAM_WORDS).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  one-cycle request to begin a load session; honoured in IDLE, DONE and ERR only.
REQ-005 in_valid  input  1  upstream byte valid.
REQ-006 in_data  input  8  upstream byte.
REQ-007 in_ready  output  1  loader can accept a byte this cycle.
REQ-008 mem_we  output  1  one-cycle write strobe to the instruction RAM.
REQ-009 mem_addr  output  ADDR_W  RAM word address for mem_we.
REQ-010 mem_wdata  output  16  RAM word for mem_we.
REQ-011 core_run  output  1  execute-enable to the downstream core; high only in DONE.
REQ-012 busy  output  1  high in LEN, HI, LO and CSUM.
REQ-013 err  output  1  high in ERR.

Function
REQ-014 States: IDLE, LEN, HI, LO, CSUM, DONE, ERR; a byte transfers only on in_valid and in_ready in the same cycle.
REQ-015 in_ready high in LEN, HI, LO and CSUM; low in all other states.
REQ-016 IDLE, DONE or ERR with start: go to LEN, clear the word counter, clear the checksum, drop core_run.
REQ-017 LEN: accepted byte N sets the word count; N=0 or N>RAM_WORDS goes to ERR, otherwise goes to HI.
REQ-018 HI: accepted byte latched as instruction bits [15:8]; go to LO.
REQ-019 LO: accepted byte forms the word {hi,lo}; the next cycle drives mem_we=1, mem_addr=counter and mem_wdata=word for exactly one cycle.
REQ-020 After the LO byte, the counter increments; if counter+1==N, go to CSUM (macro on) or DONE (macro off), otherwise go to HI.
REQ-021 Load latency: last LO byte accepted in cycle t, so mem_we in t+1 and core_run high in t+1 (macro off).
REQ-022 mem_addr and mem_wdata hold their last values when mem_we=0; no writes occur outside LO handshakes.
REQ-023 The counter never wraps; addresses run 0..N-1 in order.
REQ-024 start while busy is ignored; in_valid without in_ready is ignored and does not advance state.
REQ-025 DONE holds core_run=1 until rst or start; ERR holds err=1 until rst or start.

Reset
REQ-026 rst forces IDLE; in_ready, mem_we, core_run, busy and err are 0; counter, hi latch, checksum, mem_addr and mem_wdata are 0.
REQ-027 rst mid-session aborts with no further mem_we; words already written stay in RAM; rst has priority over start and the handshake.

Configuration
REQ-028 Macro LOADER_CHECKSUM_EN defined: the XOR of all accepted bytes, including the LEN byte, is accumulated; CSUM accepts one byte; match goes to DONE, mismatch goes to ERR.
REQ-029 LOADER_CHECKSUM_EN undefined: no CSUM state and no accumulator logic; after the last LO byte the block goes straight to DONE.

Structure
REQ-030 The shared package holds the state enum, RAM_WORDS default and the LEN/HI/LO byte-order constants; the downstream core imports the same RAM_WORDS.
REQ-031 One sub-module, loader_csum (XOR accumulator with clear and enable), is instantiated only under LOADER_CHECKSUM_EN.

Verification
REQ-032 Macro off: start; bytes 0x02,0x12,0x05,0x20,0x10 -> mem_we at addr 0 data 0x1205, then addr 1 data 0x2010; core_run=1 one cycle after the last byte.
REQ-033 LEN byte 0x00, then a separate run with LEN byte 0x81 (RAM_WORDS=128) -> err=1, no mem_we, in_ready=0.
REQ-034 Macro on: bytes 0x01,0x70,0x03 with checksum 0x72 -> DONE; same bytes with checksum 0x73 -> ERR and core_run=0.
REQ-035 in_valid toggling 1,0,1 with random gaps, plus start pulsed mid-session -> identical RAM contents to the gap-free run; start has no effect.
REQ-036 rst asserted after the HI byte of word 1 in a 3-word load -> one mem_we (addr 0) only; all outputs 0 the next cycle; state IDLE.
